// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch -- instruction fetch stage
//
// Fetches one instruction at a time over a simple req/gnt/rvalid bus. Only one
// bus request is ever outstanding. A response that arrives while the pipeline
// holds the fetch stage is parked in a one-entry buffer. A redirect from EX
// cancels whatever is in flight. Responses for cancelled requests are drained
// in DISCARD so they never reach IF/ID.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   ex_branch_flag_i    redirect request from EX (active-high)
//   ex_branch_addr_i    redirect target; low two bits are ignored
//   stalled             pipeline hold vector; only bit 0 (hold fetch) is used
//   ibus_req_o          bus request, high only in REQ
//   ibus_addr_o         bus address, always the current pc
//   ibus_gnt_i          request accepted this cycle
//   ibus_rvalid_i       read data valid
//   ibus_rdata_i        read data
//   pc_o                pc of the instruction presented to IF/ID
//   inst_o              instruction presented to IF/ID, NOP_INST when none
//   stallreq_o          no valid instruction can be supplied this cycle
// ---------------------------------------------------------------------------
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_branch_flag_i,
  input  logic [31:0] ex_branch_addr_i,
  input  logic [4:0]  stalled,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_gnt_i,
  input  logic        ibus_rvalid_i,
  input  logic [31:0] ibus_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        stallreq_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_WAIT    = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] inst_buf_q, inst_buf_d;
  logic        req_q;

  logic        avail;
  logic [31:0] avail_data;
  logic        consume;

  // Only the fetch-hold bit matters here; the rest of the vector belongs to
  // later stages.
  logic unused_stalled;
  assign unused_stalled = ^stalled[4:1];

  // Data is only ever available in WAIT: either the parked word or the word
  // arriving this cycle. A redirect takes priority over stall and consume.
  always_comb begin
    avail       = (state_q == S_WAIT) && (buf_valid_q || ibus_rvalid_i);
    avail_data  = buf_valid_q ? inst_buf_q : ibus_rdata_i;
    consume     = avail && !stalled[0] && !ex_branch_flag_i;

    state_d     = state_q;
    pc_d        = pc_q;
    buf_valid_d = buf_valid_q;
    inst_buf_d  = inst_buf_q;

    if (ex_branch_flag_i) begin
      pc_d        = {ex_branch_addr_i[31:2], 2'b00};
      buf_valid_d = 1'b0;
    end else if (consume) begin
      pc_d        = pc_q + 32'd4;
      buf_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        // An accepted request that was redirected must still have its
        // response drained.
        if (ibus_gnt_i) begin
          state_d = ex_branch_flag_i ? S_DISCARD : S_WAIT;
        end
      end
      S_WAIT: begin
        if (ex_branch_flag_i) begin
          state_d = avail ? S_REQ : S_DISCARD;
        end else if (consume) begin
          state_d = S_REQ;
        end else if (ibus_rvalid_i && !buf_valid_q) begin
          // Held by the pipeline: park the word until it can be consumed.
          buf_valid_d = 1'b1;
          inst_buf_d  = ibus_rdata_i;
        end
      end
      S_DISCARD: begin
        if (ibus_rvalid_i) begin
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, pc, buffer and the registered bus request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      buf_valid_q <= 1'b0;
      inst_buf_q  <= 32'd0;
      req_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      buf_valid_q <= buf_valid_d;
      inst_buf_q  <= inst_buf_d;
      req_q       <= (state_d == S_REQ);
    end
  end

  assign ibus_req_o  = req_q;
  assign ibus_addr_o = pc_q;
  assign pc_o        = pc_q;
  assign inst_o      = (avail && !ex_branch_flag_i) ? avail_data : NOP_INST;
  assign stallreq_o  = !avail && !ex_branch_flag_i;

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0013, instruction driven when no valid fetch data.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 ex_branch_flag_i  input  1  branch/jump redirect from EX, active-high.
REQ-006 ex_branch_addr_i  input  32  redirect target.
REQ-007 stalled  input  5  pipeline hold vector; bit0 = hold fetch stage.
REQ-008 ibus_req_o  output  1  instruction bus request.
REQ-009 ibus_addr_o  output  32  instruction bus address.
REQ-010 ibus_gnt_i  input  1  request accepted this cycle.
REQ-011 ibus_rvalid_i  input  1  read data valid; at most one outstanding request.
REQ-012 ibus_rdata_i  input  32  read data.
REQ-013 pc_o  output  32  PC of instruction presented to IF/ID.
REQ-014 inst_o  output  32  instruction presented to IF/ID.
REQ-015 stallreq_o  output  1  fetch cannot supply a valid instruction this cycle.

Function
REQ-016 FSM states: IDLE, REQ, WAIT, DISCARD; 2-bit encoding.
REQ-017 IDLE: ibus_req_o=0; next state REQ unconditionally.
REQ-018 REQ: ibus_req_o=1, ibus_addr_o=pc; ibus_gnt_i=1 -> WAIT; else stay REQ with address held.
REQ-019 WAIT: ibus_req_o=0; ibus_rvalid_i=1 -> instruction available; then REQ (next fetch) if it is consumed, else hold in WAIT with buffered data.
REQ-020 Instruction consumed in a cycle when available, stalled[0]=0 and ex_branch_flag_i=0; on consume pc <= pc+4 (32-bit wrap, 32'hFFFF_FFFC -> 0).
REQ-021 Response arriving while stalled[0]=1 SHALL be captured in a one-entry buffer (inst_buf, buf_valid=1); buffer presented until consumed; no new request while buf_valid=1.
REQ-022 Available data: buf_valid ? inst_buf : (state==WAIT && ibus_rvalid_i) ? ibus_rdata_i : none.
REQ-023 inst_o = available data, else NOP_INST; pc_o = pc always.
REQ-024 stallreq_o = 1 whenever no available data and ex_branch_flag_i=0; 0 otherwise.
REQ-025 Branch has priority over stall and consume: pc <= ex_branch_addr_i, buf_valid <= 0, inst_o = NOP_INST that cycle.
REQ-026 Branch in REQ with ibus_gnt_i=0: stay REQ, new address on next cycle.
REQ-027 Branch in REQ with ibus_gnt_i=1, or in WAIT with ibus_rvalid_i=0: -> DISCARD.
REQ-028 Branch in WAIT with ibus_rvalid_i=1, or with buf_valid=1: response dropped, -> REQ.
REQ-029 DISCARD: ibus_req_o=0; ibus_rvalid_i=1 -> data dropped, -> REQ; second branch in DISCARD updates pc only.
REQ-030 Latency: zero-wait bus (gnt in REQ cycle, rvalid next cycle) yields one instruction per 2 cycles; REQ of next fetch in cycle after consume.
REQ-031 ex_branch_addr_i bits[1:0] SHALL be forced to 0 when loaded into pc.

Reset
REQ-032 rst=0 asynchronously: state=IDLE, pc=RESET_PC, buf_valid=0, inst_buf=0; outputs ibus_req_o=0, ibus_addr_o=RESET_PC, pc_o=RESET_PC, inst_o=NOP_INST, stallreq_o=1.
REQ-033 Reset mid-transaction abandons any outstanding response; responses in first IDLE cycle after release are ignored.

Verification
REQ-034 Release reset, zero-wait memory -> first ibus_req_o at 0x0 in cycle 2, inst_o=mem[0] with pc_o=0 in cycle 3, pc_o=4 request in cycle 4.
REQ-035 gnt delayed 3 cycles -> ibus_addr_o stable at 0x8 throughout, stallreq_o=1 all wait cycles.
REQ-036 stalled[0]=1 when rvalid returns 0xDEADBEEF -> buffer holds; inst_o=0xDEADBEEF, no ibus_req_o until stall drops; then pc advances by 4.
REQ-037 Branch to 0x100 while in WAIT -> DISCARD; stale rdata never on inst_o (NOP_INST shown); next request address 0x100.
REQ-038 Branch to 0x203 coincident with stalled[0]=1 and rvalid -> pc_o=0x200, buffer empty, request to 0x200.
REQ-039 rst asserted while in WAIT -> all outputs at reset values same cycle; late rvalid ignored.
